// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM states and op-class helpers for the
// iterative multiply/divide unit (also used by the ALU decoder).
package mdu_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] MUL    = 5'd21;
  localparam logic [OPC_W-1:0] MULH   = 5'd22;
  localparam logic [OPC_W-1:0] MULHSU = 5'd23;
  localparam logic [OPC_W-1:0] MULHU  = 5'd24;
  localparam logic [OPC_W-1:0] DIV    = 5'd25;
  localparam logic [OPC_W-1:0] DIVU   = 5'd26;
  localparam logic [OPC_W-1:0] REM    = 5'd27;
  localparam logic [OPC_W-1:0] REMU   = 5'd28;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  function automatic logic is_mul(input logic [OPC_W-1:0] op);
    return op inside {MUL, MULH, MULHSU, MULHU};
  endfunction

  function automatic logic is_mulh(input logic [OPC_W-1:0] op);
    return op inside {MULH, MULHSU, MULHU};
  endfunction

  function automatic logic is_quo(input logic [OPC_W-1:0] op);
    return op inside {DIV, DIVU};
  endfunction

  function automatic logic is_rem(input logic [OPC_W-1:0] op);
    return op inside {REM, REMU};
  endfunction

  function automatic logic is_signed_a(input logic [OPC_W-1:0] op);
    return op inside {MUL, MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic is_signed_b(input logic [OPC_W-1:0] op);
    return op inside {MUL, MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: shared {hi,lo} shift register, one radix-2 step
// per cycle. Ports: load (a,b), step, div_mode; hi/lo out.
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            div_mode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [XLEN-1:0] bq;
  logic [XLEN-1:0] hi_n, lo_n, dif;
  logic [XLEN:0]   sum, shl;

  always_comb begin
    sum  = {1'b0, hi} + {1'b0, bq};
    shl  = {hi, lo[XLEN-1]};
    dif  = shl[XLEN-1:0] - bq;
    hi_n = hi;
    lo_n = lo;
    if (div_mode) begin
      // restoring: the difference is kept only when it fits
      if (shl >= {1'b0, bq}) begin
        hi_n = dif;
        lo_n = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_n = shl[XLEN-1:0];
        lo_n = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      // shift-add, LSB of lo is the current multiplier bit
      if (lo[0]) begin
        hi_n = sum[XLEN:1];
        lo_n = {sum[0], lo[XLEN-1:1]};
      end else begin
        hi_n = {1'b0, hi[XLEN-1:1]};
        lo_n = {hi[0], lo[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
      bq <= '0;
    end else if (load) begin
      hi <= '0;
      lo <= a;
      bq <= b;
    end else if (step) begin
      hi <= hi_n;
      lo <= lo_n;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle RV32M/RV64M mul/div unit. Handshake
// valid_i/ready_o in, valid_o/ready_i out, flush_i, busy_o.
// Optional macro MDU_EARLY_OUT_EN: div-by-zero, signed overflow
// and zero multiply operands skip the iterations.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = 5,
  parameter int CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [OPW-1:0]  op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  state_t            state;
  logic [CNTW-1:0]   cnt;
  logic [OPC_W-1:0]  op_n, op_q;
  logic              sa_n, sb_n, sa_q, sb_q, dz_q;
  logic [XLEN-1:0]   mag_a, mag_b, hi, lo;
  logic              accept, step, early;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res, fix_out;

  assign op_n   = OPC_W'(op_i);
  assign sa_n   = is_signed_a(op_n) & a_i[XLEN-1];
  assign sb_n   = is_signed_b(op_n) & b_i[XLEN-1];
  assign mag_a  = sa_n ? -a_i : a_i;
  assign mag_b  = sb_n ? -b_i : b_i;
  assign accept = (state == IDLE) & valid_i
                & ready_o & !flush_i;
  assign step   = (state == CALC) & !flush_i;

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .load     (accept),
    .step     (step),
    .div_mode (!is_mul(op_q)),
    .a        (mag_a),
    .b        (mag_b),
    .hi       (hi),
    .lo       (lo)
  );

  always_comb begin
    prod = {hi, lo};
    if (sa_q ^ sb_q) prod = -prod;
    quo = (sa_q ^ sb_q) ? -lo : lo;
    if (dz_q) quo = '1;
    // remainder follows the dividend; for b=0 this yields a
    rem = sa_q ? -hi : hi;
    fix_res = '0;
    unique case (1'b1)
      op_q == MUL:   fix_res = prod[XLEN-1:0];
      is_mulh(op_q): fix_res = prod[2*XLEN-1:XLEN];
      is_quo(op_q):  fix_res = quo;
      is_rem(op_q):  fix_res = rem;
      default:       fix_res = '0;
    endcase
  end

`ifdef MDU_EARLY_OUT_EN
  logic            ovf, dz, early_q;
  logic [XLEN-1:0] early_res, early_res_q;

  always_comb begin
    dz  = (b_i == '0);
    ovf = (op_n == DIV || op_n == REM)
        & (a_i == {1'b1, {(XLEN-1){1'b0}}})
        & (&b_i);
    early = (is_mul(op_n) & (a_i == '0 || b_i == '0))
          | ((is_quo(op_n) | is_rem(op_n)) & (dz | ovf));
    early_res = '0;
    if (is_quo(op_n)) early_res = dz ? '1 : a_i;
    if (is_rem(op_n)) early_res = dz ? a_i : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      early_q     <= 1'b0;
      early_res_q <= '0;
    end else if (accept) begin
      early_q     <= early;
      early_res_q <= early_res;
    end
  end

  assign fix_out = early_q ? early_res_q : fix_res;
`else
  assign early   = 1'b0;
  assign fix_out = fix_res;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      ready_o  <= 1'b1;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
      result_o <= '0;
      cnt      <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
    end else if (flush_i) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          // early-out goes straight to FIX for one-cycle latency
          state   <= early ? FIX : CALC;
          ready_o <= 1'b0;
          busy_o  <= 1'b1;
          cnt     <= '0;
          op_q    <= op_n;
          sa_q    <= sa_n;
          sb_q    <= sb_n;
          dz_q    <= (b_i == '0);
        end
        CALC: begin
          cnt <= cnt + CNTW'(1);
          if (cnt == CNTW'(XLEN - 1)) state <= FIX;
        end
        FIX: begin
          result_o <= fix_out;
          valid_o  <= 1'b1;
          state    <= DONE;
        end
        DONE: if (ready_i) begin
          state   <= IDLE;
          valid_o <= 1'b0;
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed vectors for mdu_iter with latency,
// backpressure, flush and async reset checks.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int XLEN = 32;
  localparam int LN   = XLEN + 1;
`ifdef MDU_EARLY_OUT_EN
  localparam int LE = 1;
`else
  localparam int LE = XLEN + 1;
`endif

  logic            clk_i = 0;
  logic            rst_ni;
  logic            valid_i, ready_o;
  logic [4:0]      op_i;
  logic [XLEN-1:0] a_i, b_i;
  logic            flush_i, valid_o, ready_i;
  logic [XLEN-1:0] result_o;
  logic            busy_o;

  int n_chk = 0;
  int n_pass = 0;

  mdu_iter #(.XLEN(XLEN)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // entered and left at #1 after a rising edge
  task automatic run_op(input string tag,
                        input logic [4:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input int lat,
                        input int hold);
    int n;
    bit ok;
    logic [31:0] r;
    check({tag, "/rdy"}, 64'(ready_o), 64'(1));
    valid_i = 1; op_i = op; a_i = a; b_i = b;
    tick();
    valid_i = 0;
    op_i = 5'($urandom);
    a_i = $urandom;
    b_i = $urandom;
    ready_i = (hold == 0);
    n = 0;
    ok = 1;
    while (!valid_o && n < 200) begin
      if (ready_o !== 1'b0 || busy_o !== 1'b1) ok = 0;
      tick();
      n++;
    end
    check({tag, "/lat"}, 64'(n), 64'(lat));
    check({tag, "/busy"}, 64'(ok), 64'(1));
    check({tag, "/res"}, 64'(result_o), 64'(exp));
    r = result_o;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (valid_o !== 1'b1 || result_o !== r
          || ready_o !== 1'b0) ok = 0;
    end
    if (hold > 0) check({tag, "/hold"}, 64'(ok), 64'(1));
    ready_i = 1;
    tick();
    check({tag, "/hs"}, 64'({ready_o, valid_o, busy_o}),
          64'(3'b100));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_ni = 0; valid_i = 0; op_i = 0; a_i = 0; b_i = 0;
    flush_i = 0; ready_i = 1;
    tick();
    tick();
    check("rst/ctl", 64'({ready_o, valid_o, busy_o}), 64'(3'b100));
    check("rst/res", 64'(result_o), 64'(0));
    rst_ni = 1;
    tick();

    run_op("mul", MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, LN, 0);
    run_op("mulh", MULH, 32'h80000000, 32'h80000000,
           32'h40000000, LN, 0);
    run_op("mulhu", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, LN, 0);
    run_op("mulhsu", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFF, LN, 0);
    run_op("mulh_neg", MULH, 32'hFFFFFFFD, 32'd5,
           32'hFFFFFFFF, LN, 0);
    run_op("mul_zero", MUL, 32'd0, 32'h1234, 32'd0, LE, 0);
    run_op("div", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LN, 0);
    run_op("rem", REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, LN, 0);
    run_op("div_nb", DIV, 32'd7, 32'hFFFFFFFE,
           32'hFFFFFFFD, LN, 0);
    run_op("divu", DIVU, 32'd100, 32'd7, 32'd14, LN, 5);
    run_op("remu", REMU, 32'd100, 32'd7, 32'd2, LN, 0);
    run_op("divu_max", DIVU, 32'hFFFFFFFF, 32'd1,
           32'hFFFFFFFF, LN, 0);
    run_op("remu_max", REMU, 32'hFFFFFFFF, 32'h10, 32'hF, LN, 0);
    run_op("div0", DIV, 32'd5, 32'd0, 32'hFFFFFFFF, LE, 0);
    run_op("remu0", REMU, 32'd5, 32'd0, 32'd5, LE, 0);
    run_op("div0_neg", DIV, 32'hFFFFFFFB, 32'd0,
           32'hFFFFFFFF, LE, 0);
    run_op("rem0_neg", REM, 32'hFFFFFFFB, 32'd0,
           32'hFFFFFFFB, LE, 0);
    run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF,
           32'h80000000, LE, 0);
    run_op("rem_ovf", REM, 32'h80000000, 32'hFFFFFFFF,
           32'd0, LE, 0);
    run_op("badop", 5'd0, 32'd5, 32'd3, 32'd0, LN, 0);
    run_op("rem_nb", REM, 32'd7, 32'hFFFFFFFE, 32'd1, LN, 0);

    valid_i = 1; op_i = DIVU; a_i = 100; b_i = 7;
    tick();
    valid_i = 0;
    repeat (10) tick();
    flush_i = 1;
    tick();
    flush_i = 0;
    check("flush/ctl", 64'({ready_o, valid_o, busy_o}),
          64'(3'b100));
    seen = 0;
    repeat (40) begin
      tick();
      if (valid_o) seen = 1;
    end
    check("flush/novalid", 64'(seen), 64'(0));

    flush_i = 1; valid_i = 1; op_i = MUL; a_i = 3; b_i = 3;
    tick();
    flush_i = 0; valid_i = 0;
    check("flush_req/ctl", 64'({ready_o, busy_o}), 64'(2'b10));
    run_op("after_flush", MUL, 32'd3, 32'd3, 32'd9, LN, 0);

    valid_i = 1; op_i = MUL; a_i = 6; b_i = 7;
    tick();
    valid_i = 0;
    repeat (5) tick();
    #2 rst_ni = 0;
    #1;
    check("arst/ctl", 64'({ready_o, valid_o, busy_o}),
          64'(3'b100));
    check("arst/res", 64'(result_o), 64'(0));
    tick();
    rst_ni = 1;
    tick();
    run_op("after_rst", MULHU, 32'h80000000, 32'd4,
           32'd2, LN, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
